alu_mult_ctrl: RTL and testbench

- Sequential shift-add multiplier controller that time-shares the team's 32-bit ALU (built from alu1 slices) to perform the ALU "mult" operation (alu_op 3'b010) as WIDTH iterative additions.
- Owns the multiplier FSM, iteration counter and 2*WIDTH product register.
- Drives the ALU operand/opcode inputs and consumes the ALU sum and carry-out.
- Sits between the top-level ALU op decode and the 32-bit ALU datapath.

---
 rtl/alu_mult_ctrl_pkg.sv | 19 +
 rtl/alu_mult_ctrl.sv | 115 +++++++++++
 tb/tb_alu_mult_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/alu_mult_ctrl_pkg.sv
// Shared constants for the ALU multiply controller: ALU opcodes and FSM encodings.
package alu_mult_ctrl_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_MULT = 3'b010;
  localparam logic [2:0] ALU_XOR  = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_OR   = 3'b101;
  localparam logic [2:0] ALU_SLT  = 3'b110;
  localparam logic [2:0] ALU_NOR  = 3'b111;

  localparam int unsigned STATE_W = 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/alu_mult_ctrl.sv
// Shift-add multiplier controller that borrows the shared ALU adder for WIDTH
// iterations, producing an exact unsigned 2*WIDTH-bit product.
module alu_mult_ctrl
  import alu_mult_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [2:0]         alu_op,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               alu_cout
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   alu_a_q, alu_a_d;
  logic [WIDTH-1:0]   alu_b_q, alu_b_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
      alu_a_q <= '0;
      alu_b_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mcand_q <= mcand_d;
      alu_a_q <= alu_a_d;
      alu_b_q <= alu_b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mcand_d = mcand_q;
    alu_a_d = '0;
    alu_b_d = '0;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d = multiplicand;
          hi_d    = '0;
          lo_d    = multiplier;
          count_d = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Carry-out lands in the product MSB; the ALU sum is hi + mcand.
        if (lo_q[0]) begin
          {hi_d, lo_d} = {alu_cout, alu_result, lo_q[WIDTH-1:1]};
        end else begin
          {hi_d, lo_d} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
        end
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Output registers follow the next state so they line up with hi/mcand.
    if (state_d == S_RUN) begin
      alu_a_d = hi_d;
      alu_b_d = mcand_d;
    end
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = {hi_q, lo_q};
  assign alu_a   = alu_a_q;
  assign alu_b   = alu_b_q;
  assign alu_op  = ALU_ADD;

endmodule

// File: tb/tb_alu_mult_ctrl.sv
// Directed bench for alu_mult_ctrl with a behavioural 32-bit adder standing in for the ALU.
module tb_alu_mult_ctrl;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        busy;
  logic        done;
  logic [63:0] product;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_cout;

  int errors = 0;
  int checks = 0;

  alu_mult_ctrl #(.WIDTH(32), .CNT_W(5)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .alu_cout     (alu_cout)
  );

  assign {alu_cout, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start accepted on the first edge; done must appear on the 33rd edge counting that one.
  task automatic run_mult(input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input string tag);
    int n;
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    @(posedge clk); #1;
    start        = 1'b0;
    multiplicand = $urandom;
    multiplier   = $urandom;
    n = 1;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    chk({tag, "_op"}, 64'(alu_op), 64'd0);
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'd33);
    chk({tag, "_prod"}, product, exp);
    @(posedge clk); #1;
    chk({tag, "_done_off"}, 64'(done), 64'd0);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
    chk({tag, "_hold"}, product, exp);
  endtask

  initial begin
    int n;
    int dones;
    int done_at;
    logic [63:0] prod_at_done;

    reset_n      = 1'b0;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_prod", product, 64'h0);
    chk("rst_op", 64'(alu_op), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_alu_a", 64'(alu_a), 64'd0);

    run_mult(32'd3, 32'd5, 64'd15, "m3x5");
    run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "mmax");
    run_mult(32'h1234_5678, 32'h0, 64'h0, "mzero_b");
    run_mult(32'h0, 32'hDEAD_BEEF, 64'h0, "mzero_a");

    // Second start during RUN must be ignored.
    multiplicand = 32'd7;
    multiplier   = 32'd9;
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    dones = 0;
    done_at = 0;
    prod_at_done = '0;
    while (n < 34) begin
      if (n == 10) begin
        start        = 1'b1;
        multiplicand = 32'd2;
        multiplier   = 32'd2;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      if (done) begin
        dones++;
        if (dones == 1) begin
          done_at      = n;
          prod_at_done = product;
        end
      end
    end
    chk("ign_dones", 64'(dones), 64'd1);
    chk("ign_done_at", 64'(done_at), 64'd33);
    chk("ign_prod", prod_at_done, 64'd63);
    chk("ign_idle", 64'(busy), 64'd0);
    run_mult(32'd2, 32'd2, 64'd4, "m2x2");

    // Reset mid-operation returns everything to reset values at once.
    multiplicand = 32'd100;
    multiplier   = 32'd200;
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    while (n < 15) begin
      @(posedge clk); #1;
      n++;
    end
    chk("mid_busy_pre", 64'(busy), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_done", 64'(done), 64'd0);
    chk("mid_prod", product, 64'h0);
    chk("mid_alu_a", 64'(alu_a), 64'd0);
    chk("mid_alu_b", 64'(alu_b), 64'd0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk("mid_no_done", 64'(dones), 64'd0);
    run_mult(32'd6, 32'd7, 64'd42, "m6x7");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
